// File: rtl/agendador_quadros_pkg.sv
// Shared definitions for the frame-refresh scheduler: FSM encoding,
// frame geometry and the width constants used across the slice.
package agendador_quadros_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_IDLE      = 2'd1,
        ST_START     = 2'd2,
        ST_XFER      = 2'd3
    } state_t;

    localparam int unsigned BYTES_PER_FRAME = 1024;
    localparam int unsigned ESTADO_W        = 4;
    localparam int unsigned COUNT_W         = 16;

    // Width of the animation frame index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n_frames);
        return (n_frames > 1) ? $clog2(n_frames) : 1;
    endfunction

endpackage

// File: rtl/agendador_quadros_if.sv
// Bundle between the state controller / display path and the scheduler.
// The scheduler side is the master: it commands frames and image selection.
interface agendador_quadros_if #(
    parameter int unsigned FW = 1
);
    import agendador_quadros_pkg::*;

    logic [ESTADO_W-1:0] estado;
    logic                init_done;
    logic                frame_done;
    logic                frame_start;
    logic [ESTADO_W-1:0] estado_img;
    logic [FW-1:0]       frame_idx;
    logic                busy;
    logic [COUNT_W-1:0]  frame_count;
    logic                timeout_err;

    modport master (
        input  estado, init_done, frame_done,
        output frame_start, estado_img, frame_idx, busy, frame_count, timeout_err
    );

    modport slave (
        output estado, init_done, frame_done,
        input  frame_start, estado_img, frame_idx, busy, frame_count, timeout_err
    );

endinterface

// File: rtl/agendador_quadros_divisor_tick.sv
// Free-running period divider: counts 0..TICK_CYCLES-1 and flags the last
// count. clr restarts the period from 0. Also used for attribute decay timing.
module divisor_tick #(
    parameter int unsigned TICK_CYCLES = 13_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned    CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    // Period counter; wraps on its last count or restarts on clr.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/agendador_quadros.sv
// Frame-refresh scheduler: decides when a full frame goes to the OLED (state
// change or animation tick), freezes the image selection for the whole
// transfer and guards the transfer with a watchdog.
module agendador_quadros
    import agendador_quadros_pkg::*;
#(
    parameter int unsigned TICK_CYCLES    = 13_500_000,
    parameter int unsigned N_FRAMES       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    agendador_quadros_if.master  bus
);
    localparam int unsigned    FW       = idx_width(N_FRAMES);
    localparam int unsigned    WDW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);
    localparam logic [FW-1:0]  IDX_LAST = FW'(N_FRAMES - 1);

    state_t              state_q, state_d;
    logic                start_go, done_go, abort_go;
    logic                change, tick;
    logic [ESTADO_W-1:0] estado_q;
    logic                pend_state_q, pend_tick_q;
    logic [WDW-1:0]      wd_q;
    logic                frame_start_q, busy_q, timeout_err_q;
    logic [ESTADO_W-1:0] estado_img_q;
    logic [FW-1:0]       frame_idx_q;
    logic [COUNT_W-1:0]  frame_count_q;

    assign change = (bus.estado != estado_q);

    divisor_tick #(.TICK_CYCLES(TICK_CYCLES)) u_divisor_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (change),
        .tick  (tick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_WAIT_INIT;
        else        state_q <= state_d;
    end

    // Next-state decode plus one-cycle strobes for start, completion and abort.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        done_go  = 1'b0;
        abort_go = 1'b0;
        case (state_q)
            ST_WAIT_INIT: begin
                if (bus.init_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!bus.init_done) begin
                    state_d = ST_WAIT_INIT;
                end else if (pend_state_q || pend_tick_q) begin
                    state_d  = ST_START;
                    start_go = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_XFER;
            end
            ST_XFER: begin
                // A completion in the same cycle as the limit wins: the frame did finish.
                if (bus.frame_done) begin
                    state_d = ST_IDLE;
                    done_go = 1'b1;
                end else if (wd_q == WD_LIMIT) begin
                    state_d  = ST_IDLE;
                    abort_go = 1'b1;
                end
            end
            default: state_d = ST_WAIT_INIT;
        endcase
    end

    // Change detection and pending-event flags; starting a frame consumes both flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= '0;
            pend_state_q <= 1'b1;
            pend_tick_q  <= 1'b0;
        end else begin
            estado_q <= bus.estado;
            if (start_go) begin
                pend_state_q <= 1'b0;
                pend_tick_q  <= 1'b0;
            end else begin
                if (change || abort_go) pend_state_q <= 1'b1;
                if (tick)               pend_tick_q  <= 1'b1;
            end
        end
    end

    // Watchdog: counts cycles spent in XFER, starting at 0 on the first one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                            wd_q <= '0;
        else if ((state_q == ST_XFER) && (state_d == ST_XFER)) wd_q <= wd_q + 1'b1;
        else                                                   wd_q <= '0;
    end

    // Registered outputs: handshake, latched image selection, counters and error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            estado_img_q  <= '0;
            frame_idx_q   <= '0;
            frame_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            frame_start_q <= (state_d == ST_START);
            busy_q        <= (state_d == ST_START) || (state_d == ST_XFER);
            if (start_go) begin
                estado_img_q <= bus.estado;
                if (pend_state_q)               frame_idx_q <= '0;
                else if (frame_idx_q == IDX_LAST) frame_idx_q <= '0;
                else                            frame_idx_q <= frame_idx_q + 1'b1;
            end
            if (done_go)  frame_count_q <= frame_count_q + 1'b1;
            if (abort_go) timeout_err_q <= 1'b1;
        end
    end

    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.estado_img  = estado_img_q;
    assign bus.frame_idx   = frame_idx_q;
    assign bus.frame_count = frame_count_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: doc/agendador_quadros.md
# agendador_quadros

Frame-refresh scheduler between the state controller and the image/display path. Decides when a full frame is pushed to the OLED: on every pet-state change and on a periodic animation tick. Latches the image selection (state plus animation frame index) for the whole transfer so the image controller never switches source mid-frame. Sequences the display controller through a start/done handshake, with a watchdog against a stalled transfer.

## Interface
- TICK_CYCLES, 13_500_000: clock cycles per animation tick (0.5 s at 27 MHz).
- N_FRAMES, 2: animation frames per state; frame_idx width FW = clog2(N_FRAMES), minimum 1.
- TIMEOUT_CYCLES, 2_000_000: maximum cycles allowed in XFER before abort.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- estado  in  4  current pet state from the state controller.
- init_done  in  1  level; display power-up/init sequence finished.
- frame_done  in  1  one-cycle pulse from the display controller after the last byte (byte 1023) is shifted out.
- frame_start  out  1  one-cycle pulse; starts a 1024-byte frame transfer.
- estado_img  out  4  state used by the image controller; stable from START until the end of XFER.
- frame_idx  out  FW  animation frame used by the image controller; stable from START until the end of XFER.
- busy  out  1  high in START and XFER.
- frame_count  out  16  completed frames; wraps 65535 -> 0.
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset.

## Operation
- States:
  - WAIT_INIT: waits for init_done = 1, then goes to IDLE.
  - IDLE: goes to START when pend_state or pend_tick is set and init_done = 1.
  - START: lasts one cycle; frame_start = 1; goes to XFER.
  - XFER: goes to IDLE on frame_done or on timeout.
- Change detect: estado_q is registered every cycle. A change is estado != estado_q. A change sets pend_state and clears the tick counter to 0.
- Tick: a free-running counter counts 0..TICK_CYCLES-1. Wrapping sets pend_tick.
- On the IDLE -> START transition:
  - estado_img <= estado, the live value at that moment.
  - If pend_state: frame_idx <= 0. Otherwise frame_idx <= (frame_idx+1) mod N_FRAMES.
  - Both pend flags are cleared.
- Events during START or XFER only set the pend flags. A transfer is never aborted by events.
- Multiple events before service coalesce into one frame, which uses the latest estado.
- A tick and a change arriving together produce a single frame with frame_idx = 0.
- frame_done: increments frame_count. It is ignored outside XFER.
- Timeout: the XFER cycle counter reaches TIMEOUT_CYCLES. Result: timeout_err <= 1, pend_state <= 1 (forces a resend), state <= IDLE. frame_count is unchanged.
- init_done falling in IDLE returns the block to WAIT_INIT. In START or XFER the transfer completes first.
- Reset values:
  - state WAIT_INIT
  - pend_state = 1, so the first frame is sent automatically after init
  - pend_tick = 0
  - all counters 0
  - frame_start, busy, estado_img, frame_idx, frame_count, timeout_err all 0
  - estado_q = 0
- Reset mid-transfer: all outputs return to their reset values immediately (asynchronous).

## Timing
- All outputs are registered.
- Change latency from IDLE: estado differs in cycle c -> pend_state = 1 in c+1 -> frame_start = 1 in c+2.
- Tick latency: counter wrap in cycle c -> frame_start in c+2.
- busy rises together with frame_start and falls the cycle after frame_done is sampled.
- Back-to-back: with a pend flag set during XFER, frame_start follows frame_done by exactly 2 cycles (IDLE for one cycle, then START).
- Watchdog: abort when the XFER counter reaches TIMEOUT_CYCLES, i.e. the (TIMEOUT_CYCLES+1)th cycle spent in XFER.

## Structure
- Shared package: state encoding (WAIT_INIT, IDLE, START, XFER), BYTES_PER_FRAME = 1024, width constants for estado (4) and frame_count (16).
- Sub-module: divisor_tick (parameter TICK_CYCLES; inputs clk, rst_n, clr; output tick pulse). It is reusable by the attribute controller for its decay timing.
- Scheduler FSM, pend flags, latches and watchdog live in agendador_quadros.

## Test plan
- Reset, hold init_done = 0 for 100 cycles, then raise it -> no frame_start while init_done = 0; one frame_start 2 cycles after init_done rises; estado_img = 0, frame_idx = 0.
- IDLE, estado 0 -> 3 -> frame_start 2 cycles later with estado_img = 3, frame_idx = 0; frame_done -> frame_count = 2.
- TICK_CYCLES = 8, no state changes -> frames every 8 cycles while XFER is short; frame_idx sequence 0, 1, 0, 1.
- During XFER, estado goes 3 -> 5 -> 6; estado_img stays 3 until frame_done; next frame_start 2 cycles after frame_done with estado_img = 6; exactly one extra frame.
- Tick wrap and estado change in the same cycle -> exactly one frame_start, frame_idx = 0; tick counter restarts from 0.
- TIMEOUT_CYCLES = 50, frame_done never sent -> busy falls after 51 XFER cycles; timeout_err = 1; retry frame_start 2 cycles later; frame_count unchanged; rst_n low mid-XFER -> busy = 0 and timeout_err = 0 immediately.
